// File: rtl/processor_pkg.sv
// Shared widths, instruction field positions, opcode and FSM encodings
// for the two-stage processor_core.
package processor_pkg;

   localparam int DATA_W = 16;
   localparam int PC_W   = 8;
   localparam int ADDR_W = 3;
   localparam int IMM_W  = 8;
   localparam int NREG   = 8;

   localparam int OP_HI    = 15;
   localparam int OP_LO    = 12;
   localparam int RD_HI    = 11;
   localparam int RD_LO    = 9;
   localparam int RS_HI    = 8;
   localparam int RS_LO    = 6;
   localparam int RT_HI    = 5;
   localparam int RT_LO    = 3;
   localparam int IMM_HI   = 7;
   localparam int IMM_LO   = 0;
   localparam int MADDR_HI = 2;
   localparam int MADDR_LO = 0;

   localparam logic [1:0] REG_EN_NONE = 2'b00;
   localparam logic [1:0] REG_EN_ALU  = 2'b01;
   localparam logic [1:0] REG_EN_LOAD = 2'b10;

   typedef enum logic [3:0] {
      OP_NOP  = 4'h0,
      OP_ADD  = 4'h1,
      OP_SUB  = 4'h2,
      OP_AND  = 4'h3,
      OP_OR   = 4'h4,
      OP_XOR  = 4'h5,
      OP_LDI  = 4'h6,
      OP_LD   = 4'h7,
      OP_ST   = 4'h8,
      OP_JMP  = 4'h9,
      OP_BEQZ = 4'hA,
      OP_HALT = 4'hF
   } opcode_e;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_FLUSH = 2'd1,
      ST_HALT  = 2'd2
   } state_e;

   function automatic logic is_alu_op(input opcode_e op);
      return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
             (op == OP_OR)  || (op == OP_XOR);
   endfunction

endpackage

// File: rtl/processor_if.sv
// Fetch and write-back bus between processor_core and its environment.
interface processor_if;
   logic [processor_pkg::DATA_W-1:0] inst_in;
   logic [processor_pkg::PC_W-1:0]   pc;
   logic [processor_pkg::DATA_W-1:0] inst_out;
   logic [processor_pkg::DATA_W-1:0] reg_data;
   logic [1:0]                       reg_en;
   logic [processor_pkg::ADDR_W-1:0] reg_add;
   logic [processor_pkg::DATA_W-1:0] mem_data;
   logic                             mem_en;
   logic [processor_pkg::ADDR_W-1:0] mem_add;

   modport master (
      input  inst_in,
      output pc, inst_out, reg_data, reg_en, reg_add, mem_data, mem_en, mem_add
   );

   modport slave (
      output inst_in,
      input  pc, inst_out, reg_data, reg_en, reg_add, mem_data, mem_en, mem_add
   );
endinterface

// File: rtl/processor_alu.sv
// Combinational ALU for the register-register opcodes; arithmetic wraps
// modulo 2^16 and produces no flags.
module processor_alu
   import processor_pkg::*;
(
   input  opcode_e           op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] y
);

   // Select the operation result for the current opcode.
   always_comb begin
      y = {DATA_W{1'b0}};
      case (op)
         OP_ADD:  y = a + b;
         OP_SUB:  y = a - b;
         OP_AND:  y = a & b;
         OP_OR:   y = a | b;
         OP_XOR:  y = a ^ b;
         default: y = {DATA_W{1'b0}};
      endcase
   end

endmodule

// File: rtl/processor_core.sv
// Two-stage (fetch / execute) 16-bit processor with internal register file
// and data memory; all outputs registered one cycle after the instruction is captured.
module processor_core
   import processor_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   processor_if.master bus
);

   logic [DATA_W-1:0] ir_r;
   logic [PC_W-1:0]   pc_r;
   state_e            state_r;
   logic [DATA_W-1:0] rf_r   [NREG];
   logic [DATA_W-1:0] dmem_r [NREG];

   logic [DATA_W-1:0] inst_out_r;
   logic [DATA_W-1:0] reg_data_r;
   logic [1:0]        reg_en_r;
   logic [ADDR_W-1:0] reg_add_r;
   logic [DATA_W-1:0] mem_data_r;
   logic              mem_en_r;
   logic [ADDR_W-1:0] mem_add_r;

   opcode_e           op_s;
   logic [ADDR_W-1:0] rd_s, rs_s, rt_s, maddr_s;
   logic [IMM_W-1:0]  imm_s;
   logic [DATA_W-1:0] alu_y_s;

   logic [1:0]        wr_en_s;
   logic [ADDR_W-1:0] wr_add_s;
   logic [DATA_W-1:0] wr_data_s;
   logic              st_en_s;
   logic [ADDR_W-1:0] st_add_s;
   logic [DATA_W-1:0] st_data_s;
   logic              taken_s;
   logic              halt_s;

   assign op_s    = opcode_e'(ir_r[OP_HI:OP_LO]);
   assign rd_s    = ir_r[RD_HI:RD_LO];
   assign rs_s    = ir_r[RS_HI:RS_LO];
   assign rt_s    = ir_r[RT_HI:RT_LO];
   assign imm_s   = ir_r[IMM_HI:IMM_LO];
   assign maddr_s = ir_r[MADDR_HI:MADDR_LO];

   processor_alu u_alu (
      .op (op_s),
      .a  (rf_r[rs_s]),
      .b  (rf_r[rt_s]),
      .y  (alu_y_s)
   );

   // Decode the instruction in EX into write-back, store and control requests.
   always_comb begin
      wr_en_s   = REG_EN_NONE;
      wr_add_s  = {ADDR_W{1'b0}};
      wr_data_s = {DATA_W{1'b0}};
      st_en_s   = 1'b0;
      st_add_s  = {ADDR_W{1'b0}};
      st_data_s = {DATA_W{1'b0}};
      taken_s   = 1'b0;
      halt_s    = 1'b0;
      if (state_r == ST_HALT) begin
         halt_s = 1'b0;
      end else if (is_alu_op(op_s)) begin
         wr_en_s   = REG_EN_ALU;
         wr_add_s  = rd_s;
         wr_data_s = alu_y_s;
      end else begin
         case (op_s)
            OP_LDI: begin
               wr_en_s   = REG_EN_ALU;
               wr_add_s  = rd_s;
               wr_data_s = {{(DATA_W-IMM_W){1'b0}}, imm_s};
            end
            OP_LD: begin
               wr_en_s   = REG_EN_LOAD;
               wr_add_s  = rd_s;
               wr_data_s = dmem_r[maddr_s];
            end
            OP_ST: begin
               st_en_s   = 1'b1;
               st_add_s  = maddr_s;
               st_data_s = rf_r[rd_s];
            end
            OP_JMP:  taken_s = 1'b1;
            OP_BEQZ: taken_s = (rf_r[rd_s] == {DATA_W{1'b0}});
            OP_HALT: halt_s  = 1'b1;
            default: halt_s  = 1'b0;
         endcase
      end
   end

   // Sequencer, architectural state and registered outputs; a taken branch
   // or HALT overwrites the word fetched at the same edge with a NOP.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_r       <= {PC_W{1'b0}};
         ir_r       <= {DATA_W{1'b0}};
         state_r    <= ST_RUN;
         inst_out_r <= {DATA_W{1'b0}};
         reg_data_r <= {DATA_W{1'b0}};
         reg_en_r   <= REG_EN_NONE;
         reg_add_r  <= {ADDR_W{1'b0}};
         mem_data_r <= {DATA_W{1'b0}};
         mem_en_r   <= 1'b0;
         mem_add_r  <= {ADDR_W{1'b0}};
         for (int i = 0; i < NREG; i++) begin
            rf_r[i]   <= {DATA_W{1'b0}};
            dmem_r[i] <= {DATA_W{1'b0}};
         end
      end else begin
         inst_out_r <= (state_r == ST_HALT) ? {DATA_W{1'b0}} : ir_r;
         reg_en_r   <= wr_en_s;
         reg_add_r  <= wr_add_s;
         reg_data_r <= wr_data_s;
         mem_en_r   <= st_en_s;
         mem_add_r  <= st_add_s;
         mem_data_r <= st_data_s;
         if (wr_en_s != REG_EN_NONE) begin
            rf_r[wr_add_s] <= wr_data_s;
         end
         if (st_en_s) begin
            dmem_r[st_add_s] <= st_data_s;
         end
         case (state_r)
            ST_RUN: begin
               if (halt_s) begin
                  ir_r    <= {DATA_W{1'b0}};
                  state_r <= ST_HALT;
               end else if (taken_s) begin
                  pc_r    <= imm_s;
                  ir_r    <= {DATA_W{1'b0}};
                  state_r <= ST_FLUSH;
               end else begin
                  pc_r <= pc_r + 8'd1;
                  ir_r <= bus.inst_in;
               end
            end
            ST_FLUSH: begin
               pc_r    <= pc_r + 8'd1;
               ir_r    <= bus.inst_in;
               state_r <= ST_RUN;
            end
            ST_HALT: begin
               ir_r    <= {DATA_W{1'b0}};
               state_r <= ST_HALT;
            end
            default: begin
               ir_r    <= {DATA_W{1'b0}};
               state_r <= ST_RUN;
            end
         endcase
      end
   end

   assign bus.pc       = pc_r;
   assign bus.inst_out = inst_out_r;
   assign bus.reg_data = reg_data_r;
   assign bus.reg_en   = reg_en_r;
   assign bus.reg_add  = reg_add_r;
   assign bus.mem_data = mem_data_r;
   assign bus.mem_en   = mem_en_r;
   assign bus.mem_add  = mem_add_r;

endmodule

// File: tb/tb_processor_core.sv
// Directed bench for processor_core: a ROM model feeds inst_in from pc and
// each retired cycle is compared against hand-computed expectations.
module tb_processor_core;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] imem [256];
   int          n_checks = 0;
   int          n_fail   = 0;

   processor_if bus_if ();

   assign bus_if.inst_in = imem[bus_if.pc];

   processor_core dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk_pc(input string tag, input logic [7:0] exp);
      check_eq({tag, ".pc"}, {8'h00, bus_if.pc}, {8'h00, exp});
   endtask

   task automatic chk_reg(input string tag, input logic [1:0] en, input logic [2:0] add, input logic [15:0] data);
      check_eq({tag, ".reg_en"},   {14'd0, bus_if.reg_en},  {14'd0, en});
      check_eq({tag, ".reg_add"},  {13'd0, bus_if.reg_add}, {13'd0, add});
      check_eq({tag, ".reg_data"}, bus_if.reg_data, data);
   endtask

   task automatic chk_mem(input string tag, input logic en, input logic [2:0] add, input logic [15:0] data);
      check_eq({tag, ".mem_en"},   {15'd0, bus_if.mem_en},  {15'd0, en});
      check_eq({tag, ".mem_add"},  {13'd0, bus_if.mem_add}, {13'd0, add});
      check_eq({tag, ".mem_data"}, bus_if.mem_data, data);
   endtask

   task automatic chk_idle(input string tag, input logic [15:0] inst);
      check_eq({tag, ".inst_out"}, bus_if.inst_out, inst);
      chk_reg(tag, 2'b00, 3'd0, 16'h0000);
      chk_mem(tag, 1'b0, 3'd0, 16'h0000);
   endtask

   initial begin
      rst_n = 1'b0;
      for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
      imem[8'h00] = 16'h6205;  // LDI R1,5
      imem[8'h01] = 16'h6403;  // LDI R2,3
      imem[8'h02] = 16'h1650;  // ADD R3,R1,R2
      imem[8'h03] = 16'h2888;  // SUB R4,R2,R1
      imem[8'h04] = 16'h8605;  // ST  mem[5]=R3
      imem[8'h05] = 16'h7C05;  // LD  R6=mem[5]
      imem[8'h06] = 16'hA640;  // BEQZ R3 (not taken)
      imem[8'h07] = 16'hA010;  // BEQZ R0 -> 0x10 (taken)
      imem[8'h08] = 16'h6E77;  // discarded
      imem[8'h10] = 16'h9040;  // JMP 0x40
      imem[8'h11] = 16'h6FFF;  // discarded

      repeat (2) @(negedge clk);
      chk_pc("rst", 8'h00);
      chk_idle("rst", 16'h0000);

      rst_n = 1'b1;
      tick();
      chk_pc("e1", 8'h01);
      chk_idle("e1", 16'h0000);
      tick();
      check_eq("e2.inst_out", bus_if.inst_out, 16'h6205);
      chk_reg("e2", 2'b01, 3'd1, 16'h0005);
      tick();
      chk_reg("e3", 2'b01, 3'd2, 16'h0003);
      tick();
      chk_reg("e4", 2'b01, 3'd3, 16'h0008);
      tick();
      chk_reg("e5", 2'b01, 3'd4, 16'hFFFE);
      chk_mem("e5", 1'b0, 3'd0, 16'h0000);
      tick();
      chk_mem("e6", 1'b1, 3'd5, 16'h0008);
      chk_reg("e6", 2'b00, 3'd0, 16'h0000);
      tick();
      chk_reg("e7", 2'b10, 3'd6, 16'h0008);
      chk_mem("e7", 1'b0, 3'd0, 16'h0000);
      tick();
      chk_idle("e8", 16'hA640);
      chk_pc("e8", 8'h08);
      tick();
      chk_idle("e9", 16'hA010);
      chk_pc("e9", 8'h10);
      tick();
      chk_idle("e10", 16'h0000);
      chk_pc("e10", 8'h11);
      tick();
      chk_idle("e11", 16'h9040);
      chk_pc("e11", 8'h40);
      tick();
      chk_idle("e12", 16'h0000);
      chk_pc("e12", 8'h41);

      imem[8'h00] = 16'hF000;
      repeat (190) tick();
      chk_pc("wrap_ff", 8'hFF);
      tick();
      chk_pc("wrap_00", 8'h00);
      tick();
      chk_pc("wrap_01", 8'h01);
      tick();
      chk_idle("halt_ret", 16'hF000);
      chk_pc("halt_ret", 8'h01);
      tick();
      chk_idle("halt_1", 16'h0000);
      chk_pc("halt_1", 8'h01);
      repeat (3) tick();
      chk_idle("halt_4", 16'h0000);
      chk_pc("halt_4", 8'h01);

      #2 rst_n = 1'b0;
      #1;
      chk_pc("async_rst", 8'h00);
      chk_idle("async_rst", 16'h0000);
      imem[8'h00] = 16'h1650;  // ADD R3,R1,R2 on cleared registers
      imem[8'h01] = 16'h7C05;  // LD R6=mem[5] on cleared memory
      imem[8'h02] = 16'hF000;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk_pc("r1", 8'h01);
      tick();
      chk_reg("r2", 2'b01, 3'd3, 16'h0000);
      tick();
      chk_reg("r3", 2'b10, 3'd6, 16'h0000);
      tick();
      chk_idle("r4", 16'hF000);
      chk_pc("r4", 8'h03);
      tick();
      chk_idle("r5", 16'h0000);
      chk_pc("r5", 8'h03);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/processor_core.md
PROCESSOR_CORE -- requirements
Module: processor_core

Interface
REQ-001 Parameters: none; all widths are fixed constants in processor_pkg.
REQ-002 clk  input  1  single clock; all state updates on posedge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 inst_in  input  16  instruction fetched from address pc, sampled on posedge.
REQ-005 pc  output  8  address of the instruction to be supplied next.
REQ-006 inst_out  output  16  instruction just retired; 16'h0000 for a bubble.
REQ-007 reg_data  output  16  value written to the register file this cycle.
REQ-008 reg_en  output  2  2'b00 none, 2'b01 ALU/LDI write, 2'b10 load write, 2'b11 never driven.
REQ-009 reg_add  output  3  destination register index.
REQ-010 mem_data  output  16  value written to data memory this cycle.
REQ-011 mem_en  output  1  data-memory write strobe.
REQ-012 mem_add  output  3  data-memory write address.

Function
REQ-013 Two stages: IF captures inst_in into ir and advances pc at posedge k; EX executes ir and registers all outputs at posedge k+1, one-cycle latency.
REQ-014 Field layout: op[15:12], rd[11:9], rs[8:6], rt[5:3], imm8[7:0], maddr[2:0].
REQ-015 Opcodes: 0 NOP; 1 ADD; 2 SUB; 3 AND; 4 OR; 5 XOR, each rd=rs op rt; 6 LDI rd=zero-extended imm8; 7 LD rd=mem[maddr]; 8 ST mem[maddr]=R[rd]; 9 JMP pc=imm8; A BEQZ pc=imm8 if R[rd]==0; F HALT; B-E execute as NOP.
REQ-016 Arithmetic is modulo 2^16, with no flags.
REQ-017 The 8x16 register file and 8x16 data memory are internal; writes commit at the EX posedge; reads in EX are combinational, so back-to-back dependencies need no forwarding.
REQ-018 Outputs are idle when an instruction performs no register or memory write: reg_en=00, mem_en=0, and reg_data/reg_add/mem_data/mem_add=0.
REQ-019 pc increments by 1 each cycle in RUN and wraps from 8'hFF to 8'h00.
REQ-020 A taken JMP/BEQZ loads pc=imm8 at the EX posedge and replaces the instruction captured at that same edge with NOP, a one-cycle bubble.
REQ-021 A not-taken BEQZ causes no bubble, and pc continues incrementing.
REQ-022 FSM states: RUN, FLUSH (one cycle, bubble in EX) and HALT.
REQ-023 FSM transitions: RUN->FLUSH on a taken branch; FLUSH->RUN unconditionally; RUN->HALT when HALT retires.
REQ-024 HALT is exited only by reset.
REQ-025 When HALT is in EX, pc holds and the concurrently captured instruction is discarded.
REQ-026 HALT retires with inst_out=16'hF000; every following cycle has idle outputs and inst_out=0.
REQ-027 An ST followed immediately by an LD to the same address returns the newly stored value.

Reset
REQ-028 When rst_n=0, the block immediately sets pc=0, ir=NOP, state RUN, all outputs 0, and all registers and memory words to 0.
REQ-029 Reset asserted mid-instruction or mid-flush discards all in-flight work.
REQ-030 The first instruction is fetched at the first posedge after rst_n deasserts.

Structure
REQ-031 processor_pkg SHALL hold the opcode enum, the FSM state enum, field bit-position constants, and the widths (DATA_W=16, PC_W=8, ADDR_W=3).
REQ-032 One sub-module, processor_alu, SHALL be a combinational unit for ADD/SUB/AND/OR/XOR.

Verification
REQ-033 Reset; 6205, 6403, 1650 -> reg_en=01 with add1/data0005, then add2/data0003, then add3/data0008 on consecutive cycles.
REQ-034 Then 2888 (SUB R4,R2,R1) -> reg_en=01, reg_add=4, reg_data=FFFE.
REQ-035 8605 then 7C05 -> mem_en=1, mem_add=5, mem_data=0008; next cycle reg_en=10, reg_add=6, reg_data=0008.
REQ-036 9040 at pc=0x10 -> pc=0x40 after EX; next inst_out=0000; no writes from the discarded word.
REQ-037 BEQZ on nonzero R3 (A640) -> pc keeps incrementing with no bubble; run 256 NOPs -> pc wraps FF->00.
REQ-038 F000 -> inst_out=F000 then idle; pc frozen; rst_n pulsed low mid-HALT -> pc=0 asynchronously and RUN resumes.
